mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (IF) and the data requester (MEM stage).
- Sequences each access through a fixed-latency memory protocol.
- Generates per-requester stall signals that the pipeline uses to freeze PC and the pipeline registers.
- Default priority goes to data; an anti-starvation counter guarantees forward progress for IF.

Parameters:
- AW, 64, address width.
- DW, 64, data width.
- MEM_LAT, 2, memory read latency in cycles; legal range 1..15.
- STARVE_LIM, 4, number of consecutive data grants made while IF is pending before IF is forced a grant; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  IF request; held until if_ack or if_flush
- if_addr  in  AW  IF address
- if_flush  in  1  cancels the IF request (branch taken)
- if_ack  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DW  fetched word
- if_stall  out  1  IF must hold PC and IF-ID register
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle pulse on completion
- d_rdata  out  DW  load data; valid with d_ack on reads
- d_stall  out  1  MEM stage must hold
- m_req  out  1  memory strobe; exactly one cycle per access
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data; valid MEM_LAT cycles after the m_req cycle
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0: m_req, m_we, m_addr, m_wdata, if_ack, d_ack, if_rdata, d_rdata, busy.
  - Starve counter=0; cancel flag=0.
  - Reset mid-access abandons the access; no ack is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered except the stalls.
- IDLE:
  - Arbitrate at the clock edge; no request means stay in IDLE.
  - Only d_req set: grant data.
  - Only if_req set (and if_flush=0): grant IF.
  - Both set: grant IF if starve counter == STARVE_LIM, otherwise grant data.
  - On grant: latch owner, addr, we, wdata; go to ISSUE.
- ISSUE (one cycle): m_req=1 with the latched addr, we and wdata.
  - Write: go to RESP.
  - Read: load the wait counter with MEM_LAT and go to WAIT.
- WAIT (MEM_LAT cycles):
  - Decrement the wait counter each cycle.
  - In the last WAIT cycle, capture m_rdata into the owner's rdata register and go to RESP.
- RESP (one cycle):
  - Owner's ack=1; ack is suppressed for IF when the cancel flag is set.
  - Next state is IDLE.
  - Requester must drop or update its req by the cycle after ack, because IDLE re-samples req.
- Latency, measured from a req seen in IDLE cycle T:
  - m_req at T+1.
  - Read ack at T+2+MEM_LAT.
  - Write ack at T+2.
- Stalls (combinational):
  - if_stall = if_req & ~if_flush & ~if_ack.
  - d_stall = d_req & ~d_ack.
- Starve counter:
  - Increments (saturating at STARVE_LIM) on each data grant while if_req=1.
  - Clears on an IF grant, or in any IDLE cycle with if_req=0.
- Flush:
  - if_flush while IF owns an access (ISSUE/WAIT/RESP) sets the cancel flag.
  - The memory access still completes; if_ack is not asserted; the flag clears on return to IDLE.
  - if_flush in IDLE blocks an IF grant in that cycle.
  - Data accesses are never cancelled.
- if_flush and if_ack in the same RESP cycle: ack is suppressed.
- rdata registers hold their value between acks.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, three 32-bit outputs are added:
  - if_stall_cnt: increments each cycle if_stall=1.
  - d_stall_cnt: increments each cycle d_stall=1.
  - conflict_cnt: increments each IDLE cycle where both requests are valid.
- Counters wrap at 2^32 and are cleared by reset.
- When undefined, these ports are still present, tied to 0, and no counter logic is built.

Test Plan:
- MEM_LAT=2. IF read only, addr=0x10, m_rdata=0x00500093 at T+3 → m_req at T+1 with addr 0x10, if_ack at T+4 with if_rdata=0x00500093, if_stall=1 from T to T+3.
- Data write, addr=0x8, wdata=0x2A → m_req=m_we=1 at T+1, m_wdata=0x2A, d_ack at T+2, no WAIT state.
- if_req and d_req both asserted continuously, STARVE_LIM=4 → grant order D,D,D,D,I,D,D,D,D,I; conflict_cnt increments once per IDLE cycle when ARB_PERF_CNT_EN is defined.
- IF read granted, if_flush pulsed during WAIT → access completes on the memory, if_ack stays 0, FSM reaches IDLE at T+2+MEM_LAT+1, next request arbitrates normally.
- rst driven low during WAIT → all outputs 0 immediately (asynchronously); after release, state=IDLE and no stale ack appears.
- MEM_LAT=1, back-to-back data reads at 0x0 and 0x8 → acks 4 cycles apart, d_rdata matches the memory contents in order.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status bundle of the shared memory port.
// The arbiter connects through master; the pipeline/memory side uses slave.
interface mem_port_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_stall;

    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          busy;
    logic [31:0]   if_stall_cnt;
    logic [31:0]   d_stall_cnt;
    logic [31:0]   conflict_cnt;

    modport master (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata,
        output if_ack, if_rdata, if_stall,
        output d_ack, d_rdata, d_stall,
        output m_req, m_we, m_addr, m_wdata,
        output busy,
        output if_stall_cnt, d_stall_cnt, conflict_cnt
    );

    modport slave (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata,
        input  if_ack, if_rdata, if_stall,
        input  d_ack, d_rdata, d_stall,
        input  m_req, m_we, m_addr, m_wdata,
        input  busy,
        input  if_stall_cnt, d_stall_cnt, conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF / data arbiter for one fixed-latency single-port memory.
// Define ARB_PERF_CNT_EN to build the stall and conflict counters.
module mem_port_arbiter #(
    parameter int AW         = 64,
    parameter int DW         = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LAT  = 4'(MEM_LAT);
    localparam logic [3:0] SLIM = 4'(STARVE_LIM);

    state_t        state;
    state_t        state_n;
    logic [3:0]    wait_cnt;
    logic [3:0]    wait_cnt_n;
    logic [3:0]    starve;
    logic [3:0]    starve_n;
    logic          own_if;
    logic          cancel;
    logic          cancel_n;

    logic          if_valid;
    logic          grant_d;
    logic          grant_i;
    logic          capture;
    logic          to_resp;

    logic          m_req_q;
    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    logic          if_ack_q;
    logic          d_ack_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          busy_q;

    logic          if_ack;
    logic          if_stall;
    logic          d_stall;

    assign if_valid = bus.if_req & ~bus.if_flush;

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        starve_n   = starve;
        cancel_n   = cancel;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        capture    = 1'b0;
        to_resp    = 1'b0;
        unique case (state)
            IDLE: begin
                grant_d = bus.d_req & ~(if_valid & (starve == SLIM));
                grant_i = if_valid & ~grant_d;
                if (grant_d | grant_i) begin
                    state_n = ISSUE;
                end
                if (!bus.if_req || grant_i) begin
                    starve_n = '0;
                end else if (grant_d && starve != SLIM) begin
                    starve_n = starve + 4'd1;
                end
            end
            ISSUE: begin
                if (m_we_q) begin
                    state_n = RESP;
                    to_resp = 1'b1;
                end else begin
                    state_n    = WAIT;
                    wait_cnt_n = LAT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_n = RESP;
                    to_resp = 1'b1;
                    capture = 1'b1;
                end
                wait_cnt_n = wait_cnt - 4'd1;
            end
            RESP: begin
                state_n = IDLE;
            end
        endcase
        // A flush only ever cancels an IF access already in flight
        if (state == RESP) begin
            cancel_n = 1'b0;
        end else if (state != IDLE && own_if && bus.if_flush) begin
            cancel_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve     <= '0;
            own_if     <= 1'b0;
            cancel     <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            starve   <= starve_n;
            cancel   <= cancel_n;
            m_req_q  <= grant_d | grant_i;
            busy_q   <= (state_n != IDLE);
            if (grant_d | grant_i) begin
                own_if    <= grant_i;
                m_we_q    <= grant_d & bus.d_we;
                m_addr_q  <= grant_i ? bus.if_addr : bus.d_addr;
                m_wdata_q <= grant_i ? '0 : bus.d_wdata;
            end
            if_ack_q <= to_resp & own_if & ~cancel_n;
            d_ack_q  <= to_resp & ~own_if;
            if (capture && own_if) begin
                if_rdata_q <= bus.m_rdata;
            end
            if (capture && !own_if) begin
                d_rdata_q <= bus.m_rdata;
            end
        end
    end

    // Late flush in the RESP cycle still has to kill the ack
    assign if_ack   = if_ack_q & ~bus.if_flush;
    assign if_stall = bus.if_req & ~bus.if_flush & ~if_ack;
    assign d_stall  = bus.d_req & ~d_ack_q;

    assign bus.if_ack   = if_ack;
    assign bus.if_rdata = if_rdata_q;
    assign bus.if_stall = if_stall;
    assign bus.d_ack    = d_ack_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_stall  = d_stall;
    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.busy     = busy_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt;
    logic [31:0] d_stall_cnt;
    logic [31:0] conflict_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_stall_cnt <= '0;
            d_stall_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (if_stall) begin
                if_stall_cnt <= if_stall_cnt + 32'd1;
            end
            if (d_stall) begin
                d_stall_cnt <= d_stall_cnt + 32'd1;
            end
            if (state == IDLE && if_valid && bus.d_req) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end

    assign bus.if_stall_cnt = if_stall_cnt;
    assign bus.d_stall_cnt  = d_stall_cnt;
    assign bus.conflict_cnt = conflict_cnt;
`else
    assign bus.if_stall_cnt = '0;
    assign bus.d_stall_cnt  = '0;
    assign bus.conflict_cnt = '0;
`endif
endmodule
